add32_rr_sched: RTL and testbench
=================================

Name: add32_rr_sched

Overview:
- Shares one 8-bit ripple adder slice (eight fulladder cells, with carry-in) among NREQ requesters.
- Each requester submits an NBYTES-byte addition, e.g. 32-bit SHA-256 word adds in the hashing core.
- The block arbitrates round-robin, then sequences the operation byte-serially, LSB first, chaining the carry through a register.
- It returns the sum, carry-out and requester ID on a valid/ready response port.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NBYTES, 4, operand width in bytes (1..8). W = 8*NBYTES.
- ID_W (localparam), clog2(NREQ) with a minimum of 1, width of rsp_id.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot grant/accept.
- req_a  in  NREQ*W  operand A; requester i uses [i*W +: W].
- req_b  in  NREQ*W  operand B, same packing as req_a.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_sum  out  W  (a+b) mod 2^W.
- rsp_carry  out  1  carry-out of the MSB byte.
- rsp_id  out  ID_W  index of the requester that was served.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: asynchronous, active-high, clk and rst only.
  - State goes to IDLE; byte counter, carry register, result register and rsp_id all go to 0.
  - Round-robin pointer goes to 0, so requester 0 has highest priority.
  - Outputs while rst is high and on the first cycle after release: req_ready=0, rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, busy=0.
  - Reset mid-operation discards the in-flight operation; no response is ever produced for it.
- State machine has three states: IDLE, CALC, DONE.
- IDLE:
  - req_ready is combinational.
  - It is one-hot on the first asserted req_valid searching from index ptr upward, wrapping modulo NREQ.
  - It is all-zero if no req_valid is asserted.
  - On an edge where req_valid[g]&req_ready[g]: latch A and B of requester g, set rsp_id=g, ptr=(g+1) mod NREQ, carry=0, byte index=0; go to CALC.
- CALC:
  - One byte per cycle. The slice inputs are A byte k, B byte k and the carry register.
  - At each edge, result byte k = slice sum and the carry register = slice carry-out.
  - At the edge where k = NBYTES-1, go to DONE; otherwise k increments.
  - req_ready=0 for all requesters.
- DONE:
  - rsp_valid=1; rsp_sum, rsp_carry and rsp_id are held stable while rsp_ready=0.
  - The edge with rsp_ready=1 returns to IDLE.
  - No grant is issued in the same cycle; the earliest next grant is in the following IDLE cycle.
- Latency: accept at edge T; rsp_valid rises after edge T+NBYTES. With rsp_ready held high, the earliest next accept is at edge T+NBYTES+2, giving a throughput of one operation per NBYTES+2 cycles.
- Requester obligations:
  - Hold req_valid, req_a and req_b stable until accepted.
  - Dropping req_valid before acceptance is permitted; it is treated as withdrawal.
  - Operands are captured at accept, so requester inputs are don't-care afterwards.
- Arithmetic: unsigned; the carry chain wraps only through rsp_carry. For NBYTES=1 the result equals the single slice output.
- rsp_ready while not in DONE is ignored. Only one operation is in flight; there is no queueing.
- busy = (state != IDLE).

Test Plan:
- Single op: req0 a=0x000000FF, b=0x00000001, rsp_ready=1 -> req_ready=0b0001 for one cycle; rsp_valid exactly 4 cycles after the accept edge; rsp_sum=0x00000100, rsp_carry=0, rsp_id=0.
- Full ripple: a=0xFFFFFFFF, b=0x00000001 -> rsp_sum=0x00000000, rsp_carry=1. Mixed case: a=0x12345678, b=0x9ABCDEF0 -> rsp_sum=0xACF13568, rsp_carry=0.
- Round robin: all four req_valid held high with rsp_ready=1 -> grant order 0,1,2,3,0; accepts spaced exactly 6 cycles apart.
- Backpressure: rsp_ready=0 for 10 cycles in DONE while req1 and req2 are valid -> rsp_valid, rsp_sum and rsp_id held stable; req_ready=0 throughout; on release, exactly one handshake occurs, then req1 is granted on the next cycle.
- Reset mid-op: assert rst during CALC at byte index 2 -> busy, rsp_valid and req_ready drop without waiting for a clock edge; no stale response after release; ptr=0, so with req3 and req0 valid, req0 is granted first and produces a correct sum.
- Withdrawal and sparse: req2 alone valid with ptr=3 -> wrap search grants 2; req_valid dropped in an IDLE cycle with no accept -> no grant and busy stays 0.

Source files
------------

// File: rtl/add32_rr_sched.sv
// add32_rr_sched
//   Shares one 8-bit ripple-carry adder slice among NREQ requesters. A request
//   is granted round-robin, and its NBYTES-byte operands are then added one byte
//   per cycle, LSB first, with the carry chained through a register. The sum,
//   the final carry-out and the requester index are returned on a valid/ready
//   response port.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   req_valid  per-requester request valid
//   req_ready  one-hot grant (combinational, only in IDLE)
//   req_a      operand A, requester i at [i*W +: W]
//   req_b      operand B, same packing as req_a
//   rsp_valid  result valid (DONE state)
//   rsp_ready  consumer accepts the result
//   rsp_sum    (a+b) mod 2^W
//   rsp_carry  carry-out of the MSB byte
//   rsp_id     index of the requester that was served
//   busy       high whenever the block is not IDLE
module add32_rr_sched #(
    parameter  int NREQ   = 4,
    parameter  int NBYTES = 4,
    localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*8*NBYTES-1:0]   req_a,
    input  logic [NREQ*8*NBYTES-1:0]   req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [8*NBYTES-1:0]        rsp_sum,
    output logic                       rsp_carry,
    output logic [ID_W-1:0]            rsp_id,
    output logic                       busy
);

    localparam int W     = 8 * NBYTES;
    localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(NBYTES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Eight chained full-adder cells; returns {carry_out, sum[7:0]}.
    function automatic logic [8:0] slice8(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic       cin);
        logic [8:0] r;
        logic       c;
        c = cin;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        r[8] = c;
        return r;
    endfunction

    logic [1:0]       state;
    logic [ID_W-1:0]  ptr;
    logic [CNT_W-1:0] k;
    logic             carry;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     sum_q;
    logic [ID_W-1:0]  id_q;
    logic             armed;

    logic [NREQ-1:0]  gnt;
    logic [ID_W-1:0]  gidx;
    logic [ID_W-1:0]  gnext;
    logic [ID_W-1:0]  scan;
    logic             gfound;
    logic [W-1:0]     a_sel;
    logic [W-1:0]     b_sel;
    logic [8:0]       slice;

    // Round-robin search starting at ptr, wrapping modulo NREQ.
    always_comb begin
        gnt    = '0;
        gidx   = '0;
        gnext  = '0;
        scan   = '0;
        gfound = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            scan = ID_W'((int'(ptr) + off) % NREQ);
            if (!gfound && req_valid[scan]) begin
                gnt[scan] = 1'b1;
                gidx      = scan;
                gnext     = (scan == ID_W'(NREQ - 1)) ? '0 : scan + 1'b1;
                gfound    = 1'b1;
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                a_sel = req_a[i*W +: W];
                b_sel = req_b[i*W +: W];
            end
        end
    end

    // The operand registers shift right one byte per CALC cycle, so the slice
    // always sees byte k in the low byte; the result fills in from the top and
    // is aligned once all NBYTES bytes have been processed.
    assign slice = slice8(a_q[7:0], b_q[7:0], carry);

    // armed keeps req_ready low through the first cycle after reset release.
    assign req_ready = (state == S_IDLE && armed) ? gnt : '0;
    assign rsp_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign rsp_sum   = sum_q;
    assign rsp_carry = carry;
    assign rsp_id    = id_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            ptr   <= '0;
            k     <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            id_q  <= '0;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (|(req_valid & req_ready)) begin
                        a_q   <= a_sel;
                        b_q   <= b_sel;
                        id_q  <= gidx;
                        ptr   <= gnext;
                        carry <= 1'b0;
                        k     <= '0;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    a_q   <= a_q >> 8;
                    b_q   <= b_q >> 8;
                    sum_q <= (sum_q >> 8) | (W'(slice[7:0]) << (W - 8));
                    carry <= slice[8];
                    if (k == K_LAST) begin
                        state <= S_DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add32_rr_sched.sv
module tb_add32_rr_sched;

    localparam int NREQ   = 4;
    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;
    localparam int ID_W   = 2;
    localparam int BIG    = 32'h3fffffff;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*W-1:0]    req_a;
    logic [NREQ*W-1:0]    req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [W-1:0]         rsp_sum;
    logic                 rsp_carry;
    logic [ID_W-1:0]      rsp_id;
    logic                 busy;

    add32_rr_sched #(.NREQ(NREQ), .NBYTES(NBYTES)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_id(rsp_id),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int nvec  = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference model state
    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
        int           id;
        int           acc_edge;
    } exp_t;

    exp_t            sbq[$];
    int              mptr      = 0;
    int              idle_at   = BIG;
    int              busy_from = BIG;
    int              acc_ids[$];
    int              acc_edges[$];
    int              acc_total = 0;
    int              hs_total  = 0;
    logic [NREQ-1:0] acc_pend  = '0;
    logic [W-1:0]    last_sum;
    logic            last_carry;
    logic [ID_W-1:0] last_id;

    // Stimulus state
    logic [W-1:0]    va[NREQ];
    logic [W-1:0]    vb[NREQ];
    logic [NREQ-1:0] vv;
    bit              auto_mode = 0;
    bit              rand_mode = 0;

    function automatic int rr_pick(input int p, input logic [NREQ-1:0] v);
        for (int off = 0; off < NREQ; off++) begin
            int j;
            j = (p + off) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    // Request-side monitor: predicts the grant, pushes expected results.
    always @(negedge clk) begin
        int              g;
        logic [NREQ-1:0] e;
        logic [W:0]      full;
        exp_t            x;
        if (rst) begin
            chk("req_ready_in_reset", req_ready, 0);
        end else begin
            e = '0;
            g = -1;
            if (cycle >= idle_at) begin
                g = rr_pick(mptr, req_valid);
                if (g >= 0) e[g] = 1'b1;
            end
            chk("req_ready", req_ready, e);
            if (g >= 0) begin
                full       = {1'b0, va[g]} + {1'b0, vb[g]};
                x.sum      = full[W-1:0];
                x.carry    = full[W];
                x.id       = g;
                x.acc_edge = cycle + 1;
                sbq.push_back(x);
                mptr      = (g + 1) % NREQ;
                busy_from = cycle + 1;
                idle_at   = BIG;
                acc_pend[g] = 1'b1;
                acc_ids.push_back(g);
                acc_edges.push_back(cycle + 1);
                acc_total++;
            end
        end
    end

    // Response-side monitor: pops and compares whenever a result is due.
    always @(negedge clk) begin
        logic ev;
        if (rst) begin
            chk("rsp_valid_in_reset", rsp_valid, 0);
            chk("busy_in_reset", busy, 0);
            chk("rsp_sum_in_reset", rsp_sum, 0);
            chk("rsp_carry_in_reset", rsp_carry, 0);
            chk("rsp_id_in_reset", rsp_id, 0);
        end else begin
            chk("busy", busy, (cycle >= busy_from) && (cycle < idle_at));
            ev = (sbq.size() > 0) && (cycle >= sbq[0].acc_edge + NBYTES);
            chk("rsp_valid", rsp_valid, ev);
            if (ev) begin
                chk("rsp_sum", rsp_sum, sbq[0].sum);
                chk("rsp_carry", rsp_carry, sbq[0].carry);
                chk("rsp_id", rsp_id, sbq[0].id);
                if (rsp_ready) begin
                    last_sum   = rsp_sum;
                    last_carry = rsp_carry;
                    last_id    = rsp_id;
                    void'(sbq.pop_front());
                    idle_at = cycle + 1;
                    hs_total++;
                end
            end
        end
    end

    task automatic drive();
        req_valid = vv;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = va[i];
            req_b[i*W +: W] = vb[i];
        end
    endtask

    task automatic new_ops(input int i);
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        va[i] = ($urandom_range(0, 3) == 0) ? '1 : t[W-1:0];
        t = {$urandom(), $urandom()};
        case ($urandom_range(0, 3))
            0:       vb[i] = W'(1);
            1:       vb[i] = '1;
            default: vb[i] = t[W-1:0];
        endcase
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        va[i] = a;
        vb[i] = b;
        vv[i] = 1'b1;
        drive();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc_pend[i]) begin
                acc_pend[i] = 1'b0;
                if (auto_mode) new_ops(i);
                else vv[i] = 1'b0;
            end
        end
        if (rand_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!vv[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        vv[i] = 1'b1;
                        new_ops(i);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    vv[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
        end
        drive();
    endtask

    task automatic model_reset();
        sbq.delete();
        acc_pend  = '0;
        mptr      = 0;
        idle_at   = BIG;
        busy_from = BIG;
    endtask

    task automatic clear_log();
        acc_ids.delete();
        acc_edges.delete();
    endtask

    function automatic int first_id();
        return (acc_ids.size() > 0) ? acc_ids[0] : -1;
    endfunction

    task automatic wait_acc(input int n, input string name);
        int t0;
        int k;
        t0 = acc_total;
        k  = 0;
        while (acc_total < t0 + n && k < 100) begin
            step();
            k++;
        end
        chk({name, "_accept_seen"}, acc_total >= t0 + n, 1);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((sbq.size() != 0 || vv != '0) && k < 300) begin
            step();
            k++;
        end
        chk({name, "_drained"}, (sbq.size() == 0) && (vv == '0), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, required < 100000", cycle);
        $fatal(1);
    end

    initial begin
        int c;
        int k;
        int t0;
        rst       = 1'b1;
        rsp_ready = 1'b1;
        vv        = '0;
        for (int i = 0; i < NREQ; i++) begin
            va[i] = '0;
            vb[i] = '0;
        end
        drive();
        set_req(0, 32'h000000FF, 32'h00000001);
        repeat (3) step();
        rst = 1'b0;
        idle_at = cycle + 1;
        clear_log();
        #1;
        chk("release_req_ready", req_ready, 0);
        chk("release_rsp_valid", rsp_valid, 0);
        chk("release_busy", busy, 0);
        chk("release_rsp_sum", rsp_sum, 0);
        chk("release_rsp_carry", rsp_carry, 0);
        chk("release_rsp_id", rsp_id, 0);

        // Single op on requester 0
        wait_acc(1, "t1");
        chk("t1_grant", first_id(), 0);
        wait_idle("t1");
        chk("t1_sum", last_sum, 32'h00000100);
        chk("t1_carry", last_carry, 0);
        chk("t1_id", last_id, 0);

        // Full ripple and mixed operands
        set_req(1, 32'hFFFFFFFF, 32'h00000001);
        wait_acc(1, "t2a");
        wait_idle("t2a");
        chk("t2a_sum", last_sum, 32'h00000000);
        chk("t2a_carry", last_carry, 1);
        set_req(3, 32'h12345678, 32'h9ABCDEF0);
        wait_acc(1, "t2b");
        wait_idle("t2b");
        chk("t2b_sum", last_sum, 32'hACF13568);
        chk("t2b_carry", last_carry, 0);
        chk("t2b_id", last_id, 3);

        // Round robin with all requesters held valid
        clear_log();
        auto_mode = 1;
        for (int i = 0; i < NREQ; i++) new_ops(i);
        vv = '1;
        drive();
        wait_acc(5, "t3");
        auto_mode = 0;
        vv = '0;
        drive();
        for (int i = 0; i < 5; i++) begin
            chk("t3_order", (acc_ids.size() > i) ? acc_ids[i] : -1, i % NREQ);
            if (i > 0)
                chk("t3_spacing", (acc_edges.size() > i) ? acc_edges[i] - acc_edges[i-1] : -1, NBYTES + 2);
        end
        wait_idle("t3");

        // Backpressure in DONE with req1 and req2 waiting
        clear_log();
        rsp_ready = 1'b0;
        new_ops(0);
        vv[0] = 1'b1;
        drive();
        wait_acc(1, "t4_first");
        new_ops(1); vv[1] = 1'b1;
        new_ops(2); vv[2] = 1'b1;
        drive();
        k = 0;
        while (!rsp_valid && k < 20) begin
            step();
            k++;
        end
        chk("t4_rsp_valid_seen", rsp_valid, 1);
        repeat (10) step();
        chk("t4_held_valid", rsp_valid, 1);
        c  = cycle;
        t0 = hs_total;
        rsp_ready = 1'b1;
        clear_log();
        wait_acc(1, "t4_next");
        chk("t4_next_grant", first_id(), 1);
        chk("t4_next_edge", (acc_edges.size() > 0) ? acc_edges[0] : -1, c + 2);
        chk("t4_one_handshake", hs_total - t0, 1);
        wait_idle("t4");

        // Reset in the middle of CALC, at byte index 2
        clear_log();
        new_ops(1);
        vv[1] = 1'b1;
        drive();
        wait_acc(1, "t5_first");
        step();
        step();
        new_ops(3); vv[3] = 1'b1;
        new_ops(0); vv[0] = 1'b1;
        drive();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("t5_busy_async", busy, 0);
        chk("t5_rsp_valid_async", rsp_valid, 0);
        chk("t5_req_ready_async", req_ready, 0);
        step();
        step();
        rst = 1'b0;
        idle_at = cycle + 1;
        clear_log();
        wait_acc(1, "t5_after");
        chk("t5_grant_after_reset", first_id(), 0);
        wait_idle("t5");

        // Sparse wrap search and withdrawal
        new_ops(2); vv[2] = 1'b1; drive();
        wait_acc(1, "t6a");
        wait_idle("t6a");
        clear_log();
        new_ops(2); vv[2] = 1'b1; drive();
        wait_acc(1, "t6b");
        chk("t6_wrap_grant", first_id(), 2);
        wait_idle("t6b");
        t0 = acc_total;
        new_ops(1); vv[1] = 1'b1; drive();
        #1;
        chk("t6_wd_ready_up", req_ready, 4'b0010);
        vv[1] = 1'b0; drive();
        #1;
        chk("t6_wd_ready_down", req_ready, 0);
        repeat (3) begin
            step();
            chk("t6_wd_busy", busy, 0);
        end
        chk("t6_wd_no_accept", acc_total - t0, 0);

        // Randomized traffic with withdrawals and random backpressure
        rand_mode = 1;
        repeat (400) step();
        rand_mode = 0;
        vv = '0;
        rsp_ready = 1'b1;
        drive();
        wait_idle("rand");

        chk("final_queue_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
